// File: rtl/trdb_pkg.sv
// Shared constants for the trace-debugger packet drain: data width, register
// indices and the bit layout of the STATUS and CTRL registers.
package trdb_pkg;

  localparam int XLEN = 32;

  // Register index is the APB byte offset divided by 4 (paddr[3:2]).
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STALLS = 2'd3
  } reg_idx_e;

  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_OVF_BIT   = 18;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;
  localparam int CTRL_CLR_BIT   = 2;
  localparam int CTRL_THR_LSB   = 8;
  localparam int CTRL_THR_W     = 8;

  localparam int STALL_W = 32;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trdb_fifo.sv
// Generic synchronous FIFO with push, pop and a flush that wins over both.
// The head word is presented combinationally on rdata_o.
module trdb_fifo import trdb_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNTW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTRW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o && !flush_i;
    do_pop   = pop_i && !empty_o && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers are PTRW bits wide, so the increment wraps modulo DEPTH.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is data only; an empty count makes stale contents unreachable.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/trdb_packet_drain.sv
// Packet stream sink: buffers granted trace words in a FIFO and exposes them,
// with control, status, stall counter and threshold irq, on an APB slave.
module trdb_packet_drain import trdb_pkg::*; #(
  parameter int XLEN  = trdb_pkg::XLEN,
  parameter int DEPTH = 16,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] packet_word_i,
  input  logic            packet_word_valid_i,
  output logic            grant_o,
  input  logic [11:0]     paddr_i,
  input  logic [XLEN-1:0] pwdata_i,
  input  logic            pwrite_i,
  input  logic            psel_i,
  input  logic            penable_i,
  output logic [XLEN-1:0] prdata_o,
  output logic            pready_o,
  output logic            pslverr_o,
  output logic            irq_o
);

  logic                  access, rd_acc, wr_acc, ctrl_wr;
  reg_idx_e              reg_idx;
  logic                  push, pop, flush;
  logic [XLEN-1:0]       fifo_rdata;
  logic [CNTW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [XLEN-1:0]       status_w, ctrl_w;

  logic                  en_q, en_d;
  logic [CTRL_THR_W-1:0] thresh_q, thresh_d;
  logic                  ovf_q, ovf_d;
  logic [STALL_W-1:0]    stalls_q, stalls_d;
  logic                  irq_q, irq_d;

  logic unused_bits;
  assign unused_bits = ^{paddr_i[11:4], paddr_i[1:0], pwdata_i[XLEN-1:16], pwdata_i[7:3]};

  assign pready_o = 1'b1;
  assign irq_o    = irq_q;

  always_comb begin
    access  = psel_i && penable_i;
    rd_acc  = access && !pwrite_i;
    wr_acc  = access && pwrite_i;
    reg_idx = reg_idx_e'(paddr_i[3:2]);
    ctrl_wr = wr_acc && (reg_idx == REG_CTRL);
    // Grant comes from registered state only, so full drops it the same cycle.
    grant_o = en_q && !fifo_full;
    push    = packet_word_valid_i && grant_o;
    pop     = rd_acc && (reg_idx == REG_DATA) && !fifo_empty;
    flush   = ctrl_wr && pwdata_i[CTRL_FLUSH_BIT];
  end

  trdb_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (packet_word_i),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    en_d     = en_q;
    thresh_d = thresh_q;
    ovf_d    = ovf_q;
    stalls_d = stalls_q;
    // Sticky: the source offered a word while enabled but we could not take it.
    if (packet_word_valid_i && en_q && !grant_o) ovf_d = 1'b1;
    if (ctrl_wr) begin
      en_d     = pwdata_i[CTRL_EN_BIT];
      thresh_d = pwdata_i[CTRL_THR_LSB +: CTRL_THR_W];
      if (pwdata_i[CTRL_CLR_BIT]) ovf_d = 1'b0;
    end
    if (wr_acc && (reg_idx == REG_STALLS)) begin
      stalls_d = '0;
    end else if (packet_word_valid_i && !grant_o) begin
      stalls_d = sat_inc(stalls_q);
    end
    irq_d = (thresh_q != '0) && (32'(fifo_count) >= 32'(thresh_q));
  end

  always_comb begin
    status_w                    = '0;
    status_w[CNTW-1:0]          = fifo_count;
    status_w[ST_EMPTY_BIT]      = fifo_empty;
    status_w[ST_FULL_BIT]       = fifo_full;
    status_w[ST_OVF_BIT]        = ovf_q;
    ctrl_w                      = '0;
    ctrl_w[CTRL_EN_BIT]         = en_q;
    ctrl_w[CTRL_THR_LSB +: CTRL_THR_W] = thresh_q;
    prdata_o  = '0;
    pslverr_o = 1'b0;
    if (rd_acc) begin
      case (reg_idx)
        REG_DATA: begin
          if (fifo_empty) pslverr_o = 1'b1;
          else            prdata_o  = fifo_rdata;
        end
        REG_STATUS: prdata_o = status_w;
        REG_CTRL:   prdata_o = ctrl_w;
        REG_STALLS: prdata_o = XLEN'(stalls_q);
      endcase
    end
    if (wr_acc && ((reg_idx == REG_DATA) || (reg_idx == REG_STATUS))) pslverr_o = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      thresh_q <= '0;
      ovf_q    <= 1'b0;
      stalls_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      thresh_q <= thresh_d;
      ovf_q    <= ovf_d;
      stalls_q <= stalls_d;
      irq_q    <= irq_d;
    end
  end

endmodule
